// File: rtl/spi_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI mode-0 master controller.
//   - spi_state_e : controller state encoding (IDLE, SETUP, TRANSFER, HOLD, DONE)
//   - DEFAULT_DATA_W / DEFAULT_CLK_DIV : default frame width and sclk divider
//   - sel_width() : width of a slave-select index for a given slave count
// ----------------------------------------------------------------------------
package spi_pkg;

    localparam int DEFAULT_DATA_W  = 16;
    localparam int DEFAULT_CLK_DIV = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        TRANSFER,
        HOLD,
        DONE
    } spi_state_e;

    // A single slave still needs a one-bit select port, so never return zero.
    function automatic int sel_width(input int numSlaves);
        return (numSlaves > 1) ? $clog2(numSlaves) : 1;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// ----------------------------------------------------------------------------
// spi_sclk_gen
// Divider counter and sclk toggle for the SPI master.
// Ports:
//   clk, reset      : system clock, asynchronous active-low reset
//   en_i            : run the divider; when low the counter and sclk clear
//   toggle_en_i     : allow sclk to toggle on divider wrap (low = phase timer only)
//   tick_o          : single-cycle strobe on the last cycle of each half-period
//   rise_tick_o     : tick_o on which sclk goes 0 -> 1
//   fall_tick_o     : tick_o on which sclk goes 1 -> 0
//   sclk_o          : SPI clock, idles low
// ----------------------------------------------------------------------------
module spi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic toggle_en_i,
    output logic tick_o,
    output logic rise_tick_o,
    output logic fall_tick_o,
    output logic sclk_o
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] divCnt_q, divCnt_d;
    logic       sclk_q, sclk_d;

    // The strobes describe what sclk does at the coming clk edge, so the
    // controller can act on the same edge that moves sclk.
    assign tick_o      = en_i && (divCnt_q == DIV_LAST);
    assign rise_tick_o = tick_o && toggle_en_i && !sclk_q;
    assign fall_tick_o = tick_o && toggle_en_i && sclk_q;
    assign sclk_o      = sclk_q;

    // Divider wraps at CLK_DIV-1; disabling clears it so every phase starts
    // with a full half-period.
    always_comb begin
        divCnt_d = divCnt_q;
        sclk_d   = sclk_q;
        if (!en_i) begin
            divCnt_d = '0;
            sclk_d   = 1'b0;
        end else begin
            divCnt_d = tick_o ? 8'd0 : divCnt_q + 8'd1;
            if (tick_o && toggle_en_i) begin
                sclk_d = !sclk_q;
            end
        end
    end

    // Divider and sclk registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divCnt_q <= '0;
            sclk_q   <= 1'b0;
        end else begin
            divCnt_q <= divCnt_d;
            sclk_q   <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// ----------------------------------------------------------------------------
// spi_master_ctrl
// SPI mode-0 master: latches a word and slave index on start, drives that
// slave's chip select, shifts the word out on mosi while capturing miso, and
// reports the received word with a one-cycle done pulse.
// Ports:
//   clk, reset   : system clock, asynchronous active-low reset
//   start        : request, sampled only in IDLE
//   slave_sel    : target slave index (out-of-range requests are ignored)
//   tx_data      : word to transmit
//   miso         : serial data from the selected slave
//   sclk, mosi   : SPI clock (idles low) and serial data out
//   cs_n         : one-hot-low chip selects
//   busy, done   : frame in progress / one-cycle completion pulse
//   rx_data      : last received word, held until the next done
// Build option: SPI_LSB_FIRST_EN selects LSB-first shifting in both
// directions; without it frames are MSB-first.
// ----------------------------------------------------------------------------
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter  int DATA_W     = DEFAULT_DATA_W,
    parameter  int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter  int NUM_SLAVES = 2,
    localparam int SEL_W      = sel_width(NUM_SLAVES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SEL_W-1:0]      slave_sel,
    input  logic [DATA_W-1:0]     tx_data,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic [NUM_SLAVES-1:0] cs_n,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     rx_data
);

    // One extra bit so the counter can hold DATA_W itself without wrapping.
    localparam int               BIT_W    = $clog2(DATA_W) + 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

    spi_state_e         state_q, state_d;
    logic [DATA_W-1:0]  txShift_q, txShift_d;
    logic [DATA_W-1:0]  rxShift_q, rxShift_d;
    logic [DATA_W-1:0]  rxData_q, rxData_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [BIT_W-1:0]   bitCnt_q, bitCnt_d;

    logic               frameActive, selValid, lastBit;
    logic               tick, riseTick, fallTick;
    logic               txBit;
    logic [DATA_W-1:0]  txNext, rxNext;

    assign selValid    = 32'(slave_sel) < 32'(NUM_SLAVES);
    assign frameActive = (state_q == SETUP) || (state_q == TRANSFER) || (state_q == HOLD);
    assign lastBit     = (bitCnt_q == BIT_LAST);
    assign rx_data     = rxData_q;

`ifdef SPI_LSB_FIRST_EN
    assign txBit  = txShift_q[0];
    assign txNext = {1'b0, txShift_q[DATA_W-1:1]};
    assign rxNext = {miso, rxShift_q[DATA_W-1:1]};
`else
    assign txBit  = txShift_q[DATA_W-1];
    assign txNext = {txShift_q[DATA_W-2:0], 1'b0};
    assign rxNext = {rxShift_q[DATA_W-2:0], miso};
`endif

    // The divider doubles as the SETUP/HOLD phase timer; sclk only toggles
    // in TRANSFER.
    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk         (clk),
        .reset       (reset),
        .en_i        (frameActive),
        .toggle_en_i (state_q == TRANSFER),
        .tick_o      (tick),
        .rise_tick_o (riseTick),
        .fall_tick_o (fallTick),
        .sclk_o      (sclk)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. TRANSFER ends on the falling edge that follows the
    // last rising edge, which also returns sclk low.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start && selValid) state_d = SETUP;
            SETUP:    if (tick)              state_d = TRANSFER;
            TRANSFER: if (fallTick && lastBit) state_d = HOLD;
            HOLD:     if (tick)              state_d = DONE;
            DONE:                            state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // Datapath next-state: latch on accept, sample miso on rising edges,
    // advance mosi on falling edges except the final one so the last bit
    // stays on the line through HOLD.
    always_comb begin
        txShift_d = txShift_q;
        rxShift_d = rxShift_q;
        rxData_d  = rxData_q;
        sel_d     = sel_q;
        bitCnt_d  = bitCnt_q;
        if (state_q == IDLE && start && selValid) begin
            txShift_d = tx_data;
            sel_d     = slave_sel;
            rxShift_d = '0;
            bitCnt_d  = '0;
        end
        if (riseTick) begin
            rxShift_d = rxNext;
            bitCnt_d  = bitCnt_q + 1'b1;
        end
        if (fallTick && !lastBit) begin
            txShift_d = txNext;
        end
        if (state_q == HOLD && tick) begin
            rxData_d = rxShift_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txShift_q <= '0;
            rxShift_q <= '0;
            rxData_q  <= '0;
            sel_q     <= '0;
            bitCnt_q  <= '0;
        end else begin
            txShift_q <= txShift_d;
            rxShift_q <= rxShift_d;
            rxData_q  <= rxData_d;
            sel_q     <= sel_d;
            bitCnt_q  <= bitCnt_d;
        end
    end

    // Outputs decode straight from registered state so reset reaches them
    // without waiting for a clock.
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        mosi = frameActive ? txBit : 1'b0;
        cs_n = '1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (frameActive && sel_q == SEL_W'(i)) begin
                cs_n[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// ----------------------------------------------------------------------------
// tb_spi_master_ctrl
// Scoreboard bench for spi_master_ctrl. Two instances: the default build
// (CLK_DIV=2, two slaves) and a fast one (CLK_DIV=1, three slaves). Frames
// push their expected result when issued; a monitor pops and compares on
// each done pulse. Honours SPI_LSB_FIRST_EN when defined.
// ----------------------------------------------------------------------------
module tb_spi_master_ctrl;

    localparam int DW  = 16;
    localparam int CD0 = 2;
    localparam int CD1 = 1;

    typedef struct {
        int          dut;
        logic [15:0] rx;
        logic [15:0] seq;
        logic [1:0]  sel;
        int          doneAt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    logic        startS [2];
    logic [1:0]  selS   [2];
    logic [15:0] txS    [2];
    logic        misoS  [2];
    logic        sclkS  [2];
    logic        mosiS  [2];
    logic        busyS  [2];
    logic        doneS  [2];
    logic [15:0] rxS    [2];
    logic [2:0]  csS    [2];
    logic [1:0]  cs0;
    logic [2:0]  cs1;
    logic        loopS  [2];
    logic [15:0] slvW   [2];

    exp_t expQ[$];
    int   cycle     = 0;
    int   testsRun  = 0;
    int   failCnt   = 0;

    always #5 clk = ~clk;

    // Counts clk edges; the interval after edge n is labelled cycle n+1.
    always @(posedge clk) cycle <= cycle + 1;

    assign csS[0] = {1'b1, cs0};
    assign csS[1] = cs1;

    spi_master_ctrl #(.DATA_W(DW), .CLK_DIV(CD0), .NUM_SLAVES(2)) dut0 (
        .clk(clk), .reset(reset), .start(startS[0]), .slave_sel(selS[0][0]),
        .tx_data(txS[0]), .miso(misoS[0]), .sclk(sclkS[0]), .mosi(mosiS[0]),
        .cs_n(cs0), .busy(busyS[0]), .done(doneS[0]), .rx_data(rxS[0])
    );

    spi_master_ctrl #(.DATA_W(DW), .CLK_DIV(CD1), .NUM_SLAVES(3)) dut1 (
        .clk(clk), .reset(reset), .start(startS[1]), .slave_sel(selS[1]),
        .tx_data(txS[1]), .miso(misoS[1]), .sclk(sclkS[1]), .mosi(mosiS[1]),
        .cs_n(cs1), .busy(busyS[1]), .done(doneS[1]), .rx_data(rxS[1])
    );

    function automatic int cdOf(input int d);
        return (d == 0) ? CD0 : CD1;
    endfunction

    // Bit a slave drives for its k-th sample, in wire order.
    function automatic logic slaveBit(input logic [15:0] w, input int k);
        if (k < 0 || k > 15) return 1'b0;
`ifdef SPI_LSB_FIRST_EN
        return w[k];
`else
        return w[15-k];
`endif
    endfunction

    // mosi bit sequence, first bit on the wire at position 15.
    function automatic logic [15:0] expSeq(input logic [15:0] tx);
        logic [15:0] r;
`ifdef SPI_LSB_FIRST_EN
        for (int i = 0; i < 16; i++) r[15-i] = tx[i];
`else
        r = tx;
`endif
        return r;
    endfunction

    // Slave model per instance: restarts on chip-select assertion and moves
    // to the next bit after each sclk rise, or loops mosi back.
    for (genvar g = 0; g < 2; g++) begin : gSlave
        int  idx = 0;
        wire csIdle = &csS[g];
        always @(posedge sclkS[g] or negedge csIdle) begin
            if (sclkS[g]) idx <= idx + 1;
            else          idx <= 0;
        end
        assign misoS[g] = loopS[g] ? mosiS[g] : slaveBit(slvW[g], idx);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCnt++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: tracks sclk/mosi/cs per instance and scores each done.
    logic        prevSclk [2] = '{1'b0, 1'b0};
    logic        prevBusy [2] = '{1'b0, 1'b0};
    int          riseCnt  [2] = '{0, 0};
    logic [15:0] seqS     [2];
    int          lastRise [2] = '{-1, -1};
    int          errCs    [2] = '{0, 0};
    int          errPer   [2] = '{0, 0};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [2:0] expCs;
            exp_t       e;
            if (busyS[d] && !prevBusy[d]) begin
                riseCnt[d]  = 0;
                seqS[d]     = '0;
                lastRise[d] = -1;
                errPer[d]   = 0;
            end
            expCs = 3'b111;
            if (busyS[d] && !doneS[d] && expQ.size() > 0 && expQ[0].dut == d)
                expCs[expQ[0].sel] = 1'b0;
            if (csS[d] !== expCs) errCs[d]++;
            if (!busyS[d] && sclkS[d] !== 1'b0) errCs[d]++;
            if (sclkS[d] && !prevSclk[d]) begin
                riseCnt[d]++;
                seqS[d] = {seqS[d][14:0], mosiS[d]};
                if (lastRise[d] >= 0 && (cycle - lastRise[d]) != 2 * cdOf(d)) errPer[d]++;
                lastRise[d] = cycle;
            end
            if (doneS[d]) begin
                if (expQ.size() == 0 || expQ[0].dut != d) begin
                    testsRun++;
                    failCnt++;
                    $display("[TB] FAIL dut%0d unexpected_done: got done=1, expected no done", d);
                end else begin
                    e = expQ.pop_front();
                    checkOutput($sformatf("dut%0d rx_data", d), 32'(rxS[d]), 32'(e.rx));
                    checkOutput($sformatf("dut%0d done_cycle", d), 32'(cycle + 1), 32'(e.doneAt));
                    checkOutput($sformatf("dut%0d sclk_rises", d), 32'(riseCnt[d]), 32'(DW));
                    checkOutput($sformatf("dut%0d mosi_bits", d), 32'(seqS[d]), 32'(e.seq));
                    checkOutput($sformatf("dut%0d cs_sclk_errors", d), 32'(errCs[d]), 32'd0);
                    checkOutput($sformatf("dut%0d sclk_period_errors", d), 32'(errPer[d]), 32'd0);
                    checkOutput($sformatf("dut%0d busy_in_done", d), 32'(busyS[d]), 32'd1);
                end
            end
            prevSclk[d] = sclkS[d];
            prevBusy[d] = busyS[d];
        end
    end

    // Issue one request; the expectation is queued before the accepting edge.
    task automatic applyStimulus(input int d, input logic [15:0] tx, input logic [1:0] sel,
                                 input logic loop, input logic [15:0] slv, input logic accept);
        int guard;
        @(negedge clk);
        guard = 0;
        while (busyS[d] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (busyS[d]) begin
            testsRun++;
            failCnt++;
            $display("[TB] FAIL dut%0d idle_wait: got busy=1, expected idle within 200 cycles", d);
        end
        txS[d]    = tx;
        selS[d]   = sel;
        loopS[d]  = loop;
        slvW[d]   = slv;
        startS[d] = 1'b1;
        if (accept)
            expQ.push_back('{d, (loop ? tx : slv), expSeq(tx), sel,
                             cycle + 2 + (2 * DW + 2) * cdOf(d)});
        @(negedge clk);
        startS[d] = 1'b0;
        checkOutput($sformatf("dut%0d busy_after_start", d), 32'(busyS[d]), 32'(accept));
    endtask

    task automatic waitDone(input int d);
        int guard;
        guard = 0;
        while (!doneS[d] && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!doneS[d]) begin
            testsRun++;
            failCnt++;
            $display("[TB] FAIL dut%0d done_timeout: got no done, expected done within 300 cycles", d);
            expQ.delete();
        end
    endtask

    task automatic checkResetOutputs(input int d, input string tag);
        checkOutput($sformatf("dut%0d %s sclk", d, tag), 32'(sclkS[d]), 32'd0);
        checkOutput($sformatf("dut%0d %s mosi", d, tag), 32'(mosiS[d]), 32'd0);
        checkOutput($sformatf("dut%0d %s cs_n", d, tag), 32'(csS[d]), 32'h7);
        checkOutput($sformatf("dut%0d %s busy", d, tag), 32'(busyS[d]), 32'd0);
        checkOutput($sformatf("dut%0d %s done", d, tag), 32'(doneS[d]), 32'd0);
        checkOutput($sformatf("dut%0d %s rx_data", d, tag), 32'(rxS[d]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d;
        logic [1:0] sel;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            startS[i] = 1'b0;
            selS[i]   = '0;
            txS[i]    = '0;
            loopS[i]  = 1'b1;
            slvW[i]   = '0;
        end
        repeat (3) @(negedge clk);
        checkResetOutputs(0, "reset");
        checkResetOutputs(1, "reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Loopback and slave-driven frames on the default instance.
        applyStimulus(0, 16'hA5C3, 2'd0, 1'b1, 16'h0000, 1'b1);
        waitDone(0);
        applyStimulus(0, 16'h0001, 2'd1, 1'b0, 16'hBEEF, 1'b1);
        waitDone(0);
        applyStimulus(0, 16'h8001, 2'd1, 1'b0, 16'h0001, 1'b1);
        waitDone(0);

        // start while busy (mid-frame and in the done cycle) is ignored.
        applyStimulus(0, 16'h1234, 2'd0, 1'b1, 16'h0000, 1'b1);
        repeat (9) @(negedge clk);
        txS[0]    = 16'hFFFF;
        startS[0] = 1'b1;
        @(negedge clk);
        startS[0] = 1'b0;
        waitDone(0);
        txS[0]    = 16'h00FF;
        startS[0] = 1'b1;
        @(negedge clk);
        startS[0] = 1'b0;
        checkOutput("dut0 start_in_done_ignored", 32'(busyS[0]), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("dut0 still_idle", 32'(busyS[0]), 32'd0);
        applyStimulus(0, 16'h3C3C, 2'd1, 1'b1, 16'h0000, 1'b1);
        waitDone(0);

        // Reset mid-frame aborts with outputs cleared at once.
        applyStimulus(0, 16'hC0DE, 2'd1, 1'b0, 16'h7E57, 1'b1);
        repeat (29) @(negedge clk);
        reset = 1'b0;
        #1;
        checkResetOutputs(0, "midframe_reset");
        expQ.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (80) @(negedge clk);
        checkOutput("dut0 no_done_after_abort_rx", 32'(rxS[0]), 32'd0);
        applyStimulus(0, 16'h5A5A, 2'd0, 1'b1, 16'h0000, 1'b1);
        waitDone(0);

        // Fast instance: sclk = clk/2, third slave, out-of-range select.
        applyStimulus(1, 16'hFFFF, 2'd0, 1'b1, 16'h0000, 1'b1);
        waitDone(1);
        applyStimulus(1, 16'h0000, 2'd2, 1'b1, 16'h0000, 1'b1);
        waitDone(1);
        applyStimulus(1, 16'h1111, 2'd3, 1'b1, 16'h0000, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("dut1 bad_sel_stays_idle", 32'(busyS[1]), 32'd0);
        applyStimulus(1, 16'h0F0F, 2'd2, 1'b0, 16'hBEEF, 1'b1);
        waitDone(1);

        // Randomised frames across both instances.
        for (int n = 0; n < 24; n++) begin
            d   = int'($urandom_range(0, 1));
            sel = 2'($urandom_range(0, (d == 0) ? 1 : 2));
            if (d == 1 && $urandom_range(0, 7) == 0) begin
                applyStimulus(1, 16'($urandom), 2'd3, 1'b1, 16'h0000, 1'b0);
            end else begin
                applyStimulus(d, 16'($urandom), sel, 1'($urandom_range(0, 1)), 16'($urandom), 1'b1);
                waitDone(d);
            end
        end

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
        $finish;
    end

endmodule
